ldm_stm_sequencer: RTL and testbench

//  Sequencer for ARM block transfers (LDM/STM) on the register file's write/read ports.

---
 rtl/ldm_stm_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM block-transfer sequencer
// Purpose: walks a 16-bit register list lowest-first and runs one memory
//   handshake per listed register. LDM writes the loaded words into the
//   register file and STM stores register values to memory. The updated base
//   address is reported on completion.
// Ports:
//   CLK, CLR           clock and asynchronous active-low clear
//   start, load, pre,  transfer request and operands, latched when start is
//   up, reg_list, base   seen in IDLE
//   rf_raddr/rf_rdata  register file read port (STM source)
//   rf_waddr/rf_wdata  register file write port (LDM destination), rf_RW=0 writes
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  memory handshake
//   busy, done, abort  status; wb_value is the updated base
module ldm_stm_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic        load,
  input  logic        pre,
  input  logic        up,
  input  logic [15:0] reg_list,
  input  logic [31:0] base,
  input  logic [31:0] rf_rdata,
  output logic [3:0]  rf_raddr,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_RW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [31:0] wb_value
);

  typedef enum logic [1:0] {IDLE, XFER, LOAD_WB, DONE} state_t;

  state_t      state;
  logic [15:0] remList;
  logic [31:0] addr;
  logic [31:0] wbPending;
  logic [31:0] wbReg;
  logic [31:0] loadData;
  logic [7:0]  waitCnt;
  logic        weReg;
  logic        reqReg;
  logic        rwReg;
  logic        abortReg;
  logic [3:0]  waddrReg;

  logic [3:0]  cur;
  logic [4:0]  regCount;
  logic [31:0] listBytes;
  logic [31:0] startAddr;
  logic [31:0] wbCalc;
  logic [15:0] nextList;

  // Lowest set bit of the remaining list; scanning downward lets the lowest win.
  always_comb begin
    cur = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (remList[i]) cur = 4'(i);
    end
  end

  always_comb begin
    regCount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      regCount = regCount + {4'd0, reg_list[i]};
    end
  end

  assign listBytes = {25'd0, regCount, 2'b00};

  // Lowest register always lands on the lowest address of the block.
  always_comb begin
    case ({pre, up})
      2'b01:   startAddr = base;
      2'b11:   startAddr = base + 32'd4;
      2'b00:   startAddr = base - listBytes + 32'd4;
      default: startAddr = base - listBytes;
    endcase
  end

  assign wbCalc   = up ? (base + listBytes) : (base - listBytes);
  // Clears the lowest set bit, i.e. retires register cur.
  assign nextList = remList & (remList - 16'd1);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      remList   <= 16'd0;
      addr      <= 32'd0;
      wbPending <= 32'd0;
      wbReg     <= 32'd0;
      loadData  <= 32'd0;
      waitCnt   <= 8'd0;
      weReg     <= 1'b0;
      reqReg    <= 1'b0;
      rwReg     <= 1'b1;
      abortReg  <= 1'b0;
      waddrReg  <= 4'd0;
    end else begin
      abortReg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            weReg     <= ~load;
            remList   <= reg_list;
            addr      <= {startAddr[31:2], 2'b00};
            wbPending <= wbCalc;
            waitCnt   <= 8'd0;
            if (regCount == 5'd0) begin
              wbReg <= wbCalc;
              state <= DONE;
            end else begin
              reqReg <= 1'b1;
              state  <= XFER;
            end
          end
        end
        XFER: begin
          if (!reqReg) begin
            // Idle gap between consecutive stores; request again next cycle.
            reqReg <= 1'b1;
          end else if (mem_ack) begin
            reqReg  <= 1'b0;
            waitCnt <= 8'd0;
            if (!weReg) begin
              loadData <= mem_rdata;
              waddrReg <= cur;
              rwReg    <= 1'b0;
              state    <= LOAD_WB;
            end else begin
              remList <= nextList;
              addr    <= addr + 32'd4;
              if (nextList == 16'd0) begin
                wbReg <= wbPending;
                state <= DONE;
              end
            end
          end else if (waitCnt == 8'(TIMEOUT - 1)) begin
            reqReg   <= 1'b0;
            abortReg <= 1'b1;
            state    <= IDLE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        LOAD_WB: begin
          rwReg   <= 1'b1;
          remList <= nextList;
          addr    <= addr + 32'd4;
          if (nextList == 16'd0) begin
            wbReg <= wbPending;
            state <= DONE;
          end else begin
            reqReg <= 1'b1;
            state  <= XFER;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_raddr  = cur;
  assign rf_waddr  = waddrReg;
  assign rf_wdata  = loadData;
  assign rf_RW     = rwReg;
  assign mem_req   = reqReg;
  assign mem_we    = weReg;
  assign mem_addr  = addr;
  assign mem_wdata = rf_rdata;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign abort     = abortReg;
  assign wb_value  = wbReg;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        start, load, pre, up;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic [31:0] rf_rdata;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_RW, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, busy, done, abort;
  logic [31:0] wb_value;

  logic [31:0] rfVal [16];
  assign rf_rdata = rfVal[rf_raddr];

  always #5 CLK = ~CLK;

  ldm_stm_sequencer #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .load(load), .pre(pre), .up(up),
    .reg_list(reg_list), .base(base), .rf_rdata(rf_rdata), .rf_raddr(rf_raddr),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_RW(rf_RW), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .abort(abort), .wb_value(wb_value)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
  endfunction

  logic [31:0] obsAddr[$];
  logic        obsWe[$];
  logic [31:0] obsWdata[$];
  logic [3:0]  wrReg[$];
  logic [31:0] wrData[$];
  int          doneCyc, reqCycles;
  logic        sawDone, sawAbort, busyAtDone;
  logic [31:0] sawWb;
  logic [31:0] lastWb = 32'd0;

  // Runs one block transfer acting as memory (ack after waitC idle cycles)
  // and compares what happened with a list-level model of the transfer.
  task automatic runOp(input logic ld, input logic pr, input logic u,
                       input logic [15:0] lst, input logic [31:0] bs,
                       input int waitC, input bit poke, input string tag);
    int n, k, cyc, idx, expCyc;
    logic [31:0] lowAddr, ewb;
    logic [31:0] snap [16];
    logic [3:0]  eReg[$];
    logic [31:0] eAddr[$];
    bit expAbort;

    obsAddr.delete(); obsWe.delete(); obsWdata.delete();
    wrReg.delete(); wrData.delete();
    snap = rfVal;
    n = $countones(lst);
    if (u) lowAddr = pr ? bs + 32'd4 : bs;
    else   lowAddr = pr ? bs - 32'(4 * n) : bs - 32'(4 * n) + 32'd4;
    lowAddr = lowAddr & ~32'd3;
    ewb = u ? bs + 32'(4 * n) : bs - 32'(4 * n);
    idx = 0;
    for (int r = 0; r < 16; r++) begin
      if (lst[r]) begin
        eReg.push_back(4'(r));
        eAddr.push_back(lowAddr + 32'(4 * idx));
        idx++;
      end
    end
    expAbort = (n > 0) && (waitC >= TO);
    expCyc = ld ? n * (waitC + 2) : ((n == 0) ? 0 : n * (waitC + 1) + (n - 1));

    load = ld; pre = pr; up = u; reg_list = lst; base = bs; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    k = 0; cyc = 0; sawDone = 0; sawAbort = 0; reqCycles = 0; doneCyc = -1; busyAtDone = 0;
    while (cyc < 400 && !sawDone && !sawAbort) begin
      mem_ack = 1'b0;
      if (poke && cyc == 2) begin
        start = 1'b1; reg_list = 16'hFFFF; base = 32'hDEAD0000; load = ~ld;
      end else begin
        start = 1'b0;
      end
      if (done) begin sawDone = 1; doneCyc = cyc; sawWb = wb_value; busyAtDone = busy; end
      if (abort) sawAbort = 1;
      if (!rf_RW) begin wrReg.push_back(rf_waddr); wrData.push_back(rf_wdata); end
      if (mem_req) begin
        reqCycles++;
        if (k == 0) begin
          obsAddr.push_back(mem_addr); obsWe.push_back(mem_we); obsWdata.push_back(mem_wdata);
        end
        if (k == waitC) begin
          mem_ack = 1'b1; mem_rdata = memWord(mem_addr); k = 0;
        end else begin
          k++;
        end
      end
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0; mem_ack = 1'b0;

    check({tag, " outcome done/abort"}, {30'd0, sawAbort, sawDone}, expAbort ? 32'd2 : 32'd1);
    check({tag, " busy after end"}, {31'd0, busy}, 32'd0);
    check({tag, " pulses low after end"}, {30'd0, done, abort}, 32'd0);
    if (expAbort) begin
      check({tag, " req cycles before abort"}, reqCycles, TO);
      check({tag, " transfers before abort"}, obsAddr.size(), 1);
      check({tag, " rf writes on abort"}, wrReg.size(), 0);
      check({tag, " wb_value unchanged"}, wb_value, lastWb);
      if (obsAddr.size() > 0) check({tag, " abort addr"}, obsAddr[0], eAddr[0]);
    end else begin
      check({tag, " transfer count"}, obsAddr.size(), n);
      for (int i = 0; i < n && i < obsAddr.size(); i++) begin
        check($sformatf("%s addr[%0d]", tag, i), obsAddr[i], eAddr[i]);
        check($sformatf("%s we[%0d]", tag, i), {31'd0, obsWe[i]}, {31'd0, ~ld});
        if (!ld) check($sformatf("%s wdata[%0d]", tag, i), obsWdata[i], snap[eReg[i]]);
      end
      check({tag, " rf write count"}, wrReg.size(), ld ? n : 0);
      for (int i = 0; i < wrReg.size() && i < eReg.size(); i++) begin
        check($sformatf("%s waddr[%0d]", tag, i), {28'd0, wrReg[i]}, {28'd0, eReg[i]});
        check($sformatf("%s wdata[%0d]", tag, i), wrData[i], memWord(eAddr[i]));
      end
      check({tag, " wb_value"}, sawWb, ewb);
      check({tag, " busy during done"}, {31'd0, busyAtDone}, 32'd1);
      check({tag, " done cycle"}, doneCyc, expCyc);
      if (n == 0) check({tag, " no mem_req"}, reqCycles, 0);
      lastWb = ewb;
      if (ld) for (int i = 0; i < eReg.size(); i++) rfVal[eReg[i]] = memWord(eAddr[i]);
    end
  endtask

  typedef struct {
    logic        ld, pr, u;
    logic [15:0] lst;
    logic [31:0] bs;
    int          waitC;
    bit          poke;
    logic [31:0] expFirst, expWb;
    int          expN;
  } vec_t;

  vec_t vecs [9];
  int   guard;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h000A, 32'h0000_0100, 1, 1'b0, 32'h0000_0100, 32'h0000_0108, 2};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h8001, 32'h0000_0200, 0, 1'b0, 32'h0000_01F8, 32'h0000_01F8, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0000, 32'h0000_0040, 0, 1'b0, 32'h0000_0000, 32'h0000_0040, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0003, 32'hFFFF_FFFC, 0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0004, 2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0011, 32'h0000_1000, 2, 1'b0, 32'h0000_1004, 32'h0000_1008, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h00F0, 32'h0000_0300, 0, 1'b1, 32'h0000_02F4, 32'h0000_02F0, 4};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0001, 32'h0000_0103, 3, 1'b0, 32'h0000_0100, 32'h0000_0107, 1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0000, 32'h0000_0040, 0, 1'b0, 32'h0000_0000, 32'h0000_0040, 0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h0000_1000, 0, 1'b0, 32'h0000_0FC4, 32'h0000_0FC0, 16};

    for (int r = 0; r < 16; r++) rfVal[r] = $urandom;
    CLR = 1'b0; start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0;
    reg_list = 16'd0; base = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    @(negedge CLK); @(negedge CLK);
    check("reset rf_RW", {31'd0, rf_RW}, 32'd1);
    check("reset mem_req/we", {30'd0, mem_req, mem_we}, 32'd0);
    check("reset busy/done/abort", {29'd0, busy, done, abort}, 32'd0);
    check("reset wb_value", wb_value, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    CLR = 1'b1;
    @(negedge CLK);

    // mem_ack while idle must not start anything
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    check("stray ack busy/req", {30'd0, busy, mem_req}, 32'd0);

    // Clear during XFER drops mem_req at once
    load = 1'b1; pre = 1'b0; up = 1'b1; reg_list = 16'h0003; base = 32'h800; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("rst-xfer mem_req before", {31'd0, mem_req}, 32'd1);
    CLR = 1'b0; #1;
    check("rst-xfer mem_req", {31'd0, mem_req}, 32'd0);
    check("rst-xfer rf_RW/busy", {30'd0, rf_RW, busy}, 32'd2);
    @(negedge CLK);
    CLR = 1'b1;

    // Clear during LOAD_WB: write strobe drops and no write follows
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge CLK);
    mem_ack = 1'b0;
    check("rst-wb rf_RW before", {31'd0, rf_RW}, 32'd0);
    CLR = 1'b0; #1;
    check("rst-wb rf_RW", {31'd0, rf_RW}, 32'd1);
    check("rst-wb busy/wb_value", {31'd0, busy} | wb_value, 32'd0);
    @(negedge CLK);
    CLR = 1'b1;
    guard = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (!rf_RW || mem_req || busy) guard++;
    end
    check("rst-wb quiet afterwards", guard, 0);
    lastWb = 32'd0;

    for (int v = 0; v < 9; v++) begin
      runOp(vecs[v].ld, vecs[v].pr, vecs[v].u, vecs[v].lst, vecs[v].bs,
            vecs[v].waitC, vecs[v].poke, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table wb", v), sawWb, vecs[v].expWb);
      check($sformatf("vec%0d table count", v), obsAddr.size(), vecs[v].expN);
      if (vecs[v].expN > 0 && obsAddr.size() > 0)
        check($sformatf("vec%0d table first addr", v), obsAddr[0], vecs[v].expFirst);
    end

    // Timeout with no ack, then a fresh start must be accepted
    runOp(1'b1, 1'b0, 1'b1, 16'h0004, 32'h0000_0500, 99, 1'b0, "timeout");
    runOp(1'b0, 1'b0, 1'b1, 16'h0002, 32'h0000_0600, 0, 1'b0, "after-timeout");

    for (int t = 0; t < 40; t++) begin
      logic [15:0] lst;
      int w;
      lst = ($urandom_range(0, 5) == 0) ? 16'd0 : (16'($urandom) & 16'($urandom));
      w = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 2);
      runOp(1'($urandom), 1'($urandom), 1'($urandom), lst, $urandom, w,
            1'($urandom), $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
